// File: rtl/z80_snd_responder.sv
`default_nettype none
// ============================================================================
// z80_snd_responder : sound-Z80 memory responder (ROM port, work RAM,
//                     command/reply latches, command IRQ)
// Revision 1.0
// ============================================================================
module z80_snd_responder #(
  parameter int RAM_AW = 11,
  parameter int ROM_AW = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       Z80_ADDR,
  input  logic [7:0]        Z80_DOUT,
  output logic [7:0]        Z80_DIN,
  input  logic              nMREQ,
  input  logic              nIORQ,
  input  logic              nRD,
  input  logic              nWR,
  output logic              nWAIT,
  output logic              nINT,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ack,
  input  logic [7:0]        rom_data,
  input  logic              cmd_wr,
  input  logic [7:0]        cmd_data,
  output logic [7:0]        reply_data,
  output logic              reply_stb
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ROM_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD     = 2'd2;

  localparam logic [15-RAM_AW:0] RAM_PAGE = {1'b1, {(15-RAM_AW){1'b0}}};

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              armed;
  logic              pending;
  logic [7:0]        cmd_latch;
  logic              ram_rd_q;
  logic              ram_wr_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [7:0]        ram_wdata_q;
  logic [7:0]        ram [0:(1<<RAM_AW)-1];

  logic bus_idle, mem_cyc, io_cyc, rd, start;
  logic hit_rom, hit_ram, hit_cmd, hit_rep;
  logic do_rom, do_ram_rd, do_ram_wr, do_cmd_rd, do_reply, do_ff, rom_done;

  assign bus_idle = nRD & nWR;
  assign rd       = ~nRD;
  assign mem_cyc  = ~nMREQ & ~bus_idle;
  assign io_cyc   = nMREQ & ~nIORQ & ~bus_idle;
  // armed stays low after reset until the strobes have been seen released
  assign start    = (state == S_IDLE) & armed & (mem_cyc | io_cyc);

  assign hit_rom = ~Z80_ADDR[15];
  assign hit_ram = (Z80_ADDR[15:RAM_AW] == RAM_PAGE);
  assign hit_cmd = (Z80_ADDR == 16'hA000);
  assign hit_rep = (Z80_ADDR == 16'hC000);

  assign nINT = ~pending;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (start)    state_next = do_rom ? S_ROM_WAIT : S_HOLD;
      S_ROM_WAIT: if (rom_ack)  state_next = S_HOLD;
      S_HOLD:     if (bus_idle) state_next = S_IDLE;
      default:                  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    do_rom    = start & mem_cyc & rd & hit_rom;
    do_ram_rd = start & mem_cyc & rd & hit_ram;
    do_ram_wr = start & mem_cyc & ~rd & hit_ram;
    do_cmd_rd = start & mem_cyc & rd & hit_cmd;
    do_reply  = start & mem_cyc & ~rd & hit_rep;
    do_ff     = start & rd & ~(do_rom | do_ram_rd | do_cmd_rd);
    rom_done  = (state == S_ROM_WAIT) & rom_ack;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed      <= 1'b0;
      Z80_DIN    <= 8'hFF;
      nWAIT      <= 1'b1;
      rom_req    <= 1'b0;
      rom_addr   <= '0;
      reply_data <= 8'h00;
      reply_stb  <= 1'b0;
      cmd_latch  <= 8'h00;
      pending    <= 1'b0;
      ram_rd_q   <= 1'b0;
      ram_wr_q   <= 1'b0;
    end else begin
      if (bus_idle) armed <= 1'b1;
      reply_stb <= do_reply;
      if (do_reply) reply_data <= Z80_DOUT;
      if (do_rom) begin
        rom_addr <= Z80_ADDR[ROM_AW-1:0];
        rom_req  <= 1'b1;
        nWAIT    <= 1'b0;
      end
      if (rom_done) begin
        Z80_DIN <= rom_data;
        rom_req <= 1'b0;
        nWAIT   <= 1'b1;
      end
      if (do_cmd_rd) Z80_DIN <= cmd_latch;
      if (do_ff)     Z80_DIN <= 8'hFF;
      ram_rd_q <= do_ram_rd;
      ram_wr_q <= do_ram_wr;
      if (ram_rd_q) Z80_DIN <= ram[ram_addr_q];
      // a new command in the same clk as the latch read keeps the IRQ pending
      if (cmd_wr) begin
        cmd_latch <= cmd_data;
        pending   <= 1'b1;
      end else if (do_cmd_rd) begin
        pending   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_ram_rd | do_ram_wr) begin
      ram_addr_q  <= Z80_ADDR[RAM_AW-1:0];
      ram_wdata_q <= Z80_DOUT;
    end
    if (ram_wr_q) ram[ram_addr_q] <= ram_wdata_q;
  end

endmodule
`default_nettype wire

// File: doc/z80_snd_responder.md
# z80_snd_responder

Memory-side responder for the sound Z80 bus. Decodes the CPU's memory strobes and serves four targets: banked-free program ROM fetched over an external request/acknowledge port with Z80 wait-state insertion, 2 KB internal work RAM, a command latch written by the main CPU, and a reply latch. It also raises the Z80 interrupt on a new command. It sits between the Z80 CPU wrapper and the sound ROM / main-CPU interface.

## Interface
- RAM_AW, 11, work-RAM address width (2 KB)
- ROM_AW, 15, ROM address width (32 KB)

- clk  in  1  system clock; CPU clock enable derived from it
- reset  in  1  synchronous, active-high
- Z80_ADDR  in  16  CPU address
- Z80_DOUT  in  8  CPU write data
- Z80_DIN  out  8  read data to CPU, registered
- nMREQ, nIORQ, nRD, nWR  in  1 each  CPU strobes, active-low
- nWAIT  out  1  wait request to CPU, registered
- nINT  out  1  interrupt request to CPU, registered
- rom_addr  out  ROM_AW  ROM fetch address
- rom_req  out  1  ROM fetch request, level
- rom_ack  in  1  one-clk pulse; rom_data valid same cycle
- rom_data  in  8  ROM data
- cmd_wr  in  1  one-clk pulse from main CPU side
- cmd_data  in  8  command byte
- reply_data  out  8  last byte written by Z80 to reply latch
- reply_stb  out  1  one-clk pulse on reply write

## Operation
- Memory map (memory cycles only, nMREQ low):
  - 0x0000–0x7FFF read: ROM via external port. Writes ignored.
  - 0x8000–0x87FF: work RAM, read/write.
  - 0xA000: command latch read. Read clears the IRQ pending flag.
  - 0xC000: reply latch write.
  - All other reads return 0xFF. Other writes are ignored.
- IO cycles (nIORQ low) are not decoded: Z80_DIN = 0xFF, no wait.
- Access start = first clk where nMREQ=0 and (nRD=0 or nWR=0) while the FSM is in IDLE. Each access acts exactly once (one RAM write, one latch clear, one reply_stb), however many clk the strobe stays low.
- FSM states: IDLE, ROM_WAIT, HOLD.
  - IDLE → ROM_WAIT on a ROM read start. This sets rom_addr=Z80_ADDR[14:0], rom_req=1, nWAIT=0.
  - IDLE → HOLD on any other start. The target action is performed and Z80_DIN is loaded.
  - ROM_WAIT → HOLD on rom_ack. This loads Z80_DIN=rom_data, sets rom_req=0, nWAIT=1.
  - HOLD → IDLE when nRD and nWR are both high.
- Command IRQ:
  - cmd_wr loads the command latch and sets pending.
  - nINT = ~pending, registered.
  - If cmd_wr and the latch-read clear occur in the same clk, set wins: the new byte is latched and pending stays 1.
  - The read returns the latch value from before that clk.
- Reply: a 0xC000 write loads reply_data=Z80_DOUT and pulses reply_stb for 1 clk.
- Z80_DIN holds its last value between accesses.

## Timing
- Reset values:
  - Z80_DIN=0xFF, nWAIT=1, nINT=1, rom_req=0, rom_addr=0.
  - reply_data=0, reply_stb=0, command latch=0, pending=0.
  - FSM=IDLE. RAM contents are not reset.
- nWAIT falls the clk after the ROM access start is detected. The system clk must run at least 2 clk per CPU clock enable, so the CPU sees wait at its T2 sample.
- ROM latency: Z80_DIN is valid, and nWAIT=1, the clk after rom_ack. rom_ack may arrive any number of clk after rom_req. rom_req stays high until ack.
- RAM read: synchronous, Z80_DIN valid 2 clk after access start. RAM write occurs on the start clk + 1.
- Latch read, 0xFF reads, IO reads: Z80_DIN valid 1 clk after start.
- Reset mid-ROM-fetch:
  - Return to IDLE, rom_req=0, nWAIT=1 on the next clk.
  - A late rom_ack arriving in IDLE is ignored.
- A strobe still low when reset releases is not treated as a new start until nRD and nWR have both been seen high.

## Test plan
- Reset: assert reset with a ROM fetch outstanding → next clk rom_req=0, nWAIT=1, nINT=1, Z80_DIN=0xFF. Then pulse rom_ack=1 → no state change.
- ROM read at 0x1234, ack after 7 clk with rom_data=0x5A:
  - rom_addr=0x1234, rom_req high.
  - nWAIT low from start+1 until the clk after ack.
  - Z80_DIN=0x5A. Exactly one request issued.
- RAM: write 0x3C to 0x8123 with the strobe held 6 clk, then read 0x8123 → Z80_DIN=0x3C at start+2. Read 0x8800 → 0xFF.
- IRQ:
  - cmd_wr with 0x81 → nINT=0 next clk.
  - Z80 reads 0xA000 → 0x81 returned, nINT=1.
  - cmd_wr 0x82 in the same clk as a read start → read returns 0x81, latch=0x82, nINT stays 0.
- Reply: write 0x77 to 0xC000 with the strobe held 5 clk → reply_data=0x77, exactly one reply_stb pulse.
- IO read at any port → Z80_DIN=0xFF, nWAIT stays 1, no rom_req.
